// File: rtl/rat_pkg.sv
// Shared types and defaults for the register alias table and its checkpoint store.
package rat_pkg;

  localparam int RAT_TAG_W    = 5;
  localparam int RAT_NUM_CKPT = 4;
  localparam int RAT_NUM_ARCH = 32;
  localparam int RAT_REG_W    = 5;

  typedef struct packed {
    logic                 busy;
    logic [RAT_TAG_W-1:0] tag;
  } rat_entry_t;

  typedef logic [$clog2(RAT_NUM_CKPT)-1:0] rat_ckpt_id_t;

  // What the table does this cycle, in priority order flush > restore > update.
  typedef enum logic [1:0] {
    RAT_OP_UPDATE,
    RAT_OP_RESTORE,
    RAT_OP_FLUSH
  } rat_op_e;

  // Index width that stays at least one bit for single-entry configurations.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rat_ckpt_if.sv
// Dispatch-side bundle of the rename table: lookups, rename writes, CDB, checkpoint control.
interface rat_ckpt_if
  import rat_pkg::*;
#(
  parameter int DISPATCH_W = 2,
  parameter int CDB_W      = 2,
  parameter int NUM_CKPT   = 4,
  parameter int TAG_W      = RAT_TAG_W
);
  localparam int SLOT_W = clog2_min1(DISPATCH_W);
  localparam int ID_W   = clog2_min1(NUM_CKPT);

  logic [DISPATCH_W-1:0][RAT_REG_W-1:0] rs1;
  logic [DISPATCH_W-1:0][RAT_REG_W-1:0] rs2;
  logic [DISPATCH_W-1:0]                rs1_busy;
  logic [DISPATCH_W-1:0]                rs2_busy;
  logic [DISPATCH_W-1:0][TAG_W-1:0]     rs1_tag;
  logic [DISPATCH_W-1:0][TAG_W-1:0]     rs2_tag;
  logic [DISPATCH_W-1:0]                we;
  logic [DISPATCH_W-1:0][RAT_REG_W-1:0] rd;
  logic [DISPATCH_W-1:0][TAG_W-1:0]     tag_in;
  logic [CDB_W-1:0]                     cdb_valid;
  logic [CDB_W-1:0][TAG_W-1:0]          cdb_tag;
  logic                                 ckpt_save;
  logic [SLOT_W-1:0]                    ckpt_slot;
  logic [ID_W-1:0]                      ckpt_id;
  logic                                 ckpt_full;
  logic                                 ckpt_ovf;
  logic                                 restore;
  logic [ID_W-1:0]                      restore_id;
  logic [NUM_CKPT-1:0]                  ckpt_free_mask;
  logic                                 flush;

  modport master (
    output rs1, rs2, we, rd, tag_in, cdb_valid, cdb_tag, ckpt_save, ckpt_slot,
           restore, restore_id, ckpt_free_mask, flush,
    input  rs1_busy, rs2_busy, rs1_tag, rs2_tag, ckpt_id, ckpt_full, ckpt_ovf
  );

  modport slave (
    input  rs1, rs2, we, rd, tag_in, cdb_valid, cdb_tag, ckpt_save, ckpt_slot,
           restore, restore_id, ckpt_free_mask, flush,
    output rs1_busy, rs2_busy, rs1_tag, rs2_tag, ckpt_id, ckpt_full, ckpt_ovf
  );

endinterface

// File: rtl/rat_ckpt_alloc.sv
// Checkpoint slot allocator: valid bitmap, lowest-free grant, full and overflow flags.
module rat_ckpt_alloc
  import rat_pkg::*;
#(
  parameter int NUM_CKPT = RAT_NUM_CKPT,
  parameter int ID_W     = clog2_min1(NUM_CKPT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                save_req,
  input  logic                save_block,
  input  logic                restore_en,
  input  logic [ID_W-1:0]     restore_id,
  input  logic [NUM_CKPT-1:0] free_mask,
  input  logic                flush,
  output logic [NUM_CKPT-1:0] valid,
  output logic [ID_W-1:0]     id,
  output logic                full,
  output logic                ovf,
  output logic                save_en
);

  logic [NUM_CKPT-1:0] valid_reg;
  logic [NUM_CKPT-1:0] valid_next;

  // Grant is taken from the registered bitmap, so an id freed this cycle is not reused until next.
  always_comb begin
    id = '0;
    for (int k = NUM_CKPT - 1; k >= 0; k--) begin
      if (!valid_reg[k]) id = ID_W'(k);
    end
  end

  assign full    = &valid_reg;
  assign ovf     = save_req & full;
  assign save_en = save_req & ~save_block & ~full;
  assign valid   = valid_reg;

  always_comb begin
    valid_next = valid_reg & ~free_mask;
    if (restore_en) valid_next[restore_id] = 1'b0;
    if (save_en)    valid_next[id] = 1'b1;
    if (flush)      valid_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_reg <= '0;
    else        valid_reg <= valid_next;
  end

endmodule

// File: rtl/rat_ckpt.sv
// Multi-issue register alias table with branch checkpoints: lookup, rename,
// CDB clear, snapshot and mispredict restore.
module rat_ckpt
  import rat_pkg::*;
#(
  parameter int DISPATCH_W = 2,
  parameter int CDB_W      = 2,
  parameter int NUM_CKPT   = RAT_NUM_CKPT,
  parameter int TAG_W      = RAT_TAG_W,
  parameter int NUM_ARCH   = RAT_NUM_ARCH
) (
  input logic       clk,
  input logic       rst_n,
  rat_ckpt_if.slave bus
);

  localparam int ID_W = clog2_min1(NUM_CKPT);

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t table_reg  [NUM_ARCH];
  entry_t table_next [NUM_ARCH];
  entry_t table_clr  [NUM_ARCH];
  entry_t table_wr   [NUM_ARCH];
  entry_t snap       [NUM_ARCH];
  entry_t ckpt_reg   [NUM_CKPT][NUM_ARCH];
  entry_t ckpt_clr   [NUM_CKPT][NUM_ARCH];
  entry_t ckpt_next  [NUM_CKPT][NUM_ARCH];
  entry_t lk1        [DISPATCH_W];
  entry_t lk2        [DISPATCH_W];

  logic [NUM_CKPT-1:0] ckpt_valid;
  logic [ID_W-1:0]     alloc_id;
  logic                save_en;
  logic                restore_hit;
  rat_op_e             op;

  // An entry drops to idle when any live CDB port broadcasts the tag it is waiting on.
  function automatic entry_t cdb_clear(input entry_t e, input logic [CDB_W-1:0] v,
                                       input logic [CDB_W-1:0][TAG_W-1:0] t);
    entry_t r;
    r = e;
    for (int c = 0; c < CDB_W; c++) begin
      if (e.busy && v[c] && (t[c] == e.tag)) r = '0;
    end
    return r;
  endfunction

  always_comb begin
    if (bus.flush)        op = RAT_OP_FLUSH;
    else if (bus.restore) op = RAT_OP_RESTORE;
    else                  op = RAT_OP_UPDATE;
  end

  assign restore_hit = (op == RAT_OP_RESTORE) && ckpt_valid[bus.restore_id];

  rat_ckpt_alloc #(
    .NUM_CKPT (NUM_CKPT),
    .ID_W     (ID_W)
  ) u_alloc (
    .clk        (clk),
    .rst_n      (rst_n),
    .save_req   (bus.ckpt_save),
    .save_block (bus.flush | bus.restore),
    .restore_en (op == RAT_OP_RESTORE),
    .restore_id (bus.restore_id),
    .free_mask  (bus.ckpt_free_mask),
    .flush      (bus.flush),
    .valid      (ckpt_valid),
    .id         (alloc_id),
    .full       (bus.ckpt_full),
    .ovf        (bus.ckpt_ovf),
    .save_en    (save_en)
  );

  assign bus.ckpt_id = alloc_id;

  // Lookups: table, then same-cycle writeback, then the youngest older slot of this group.
  always_comb begin
    bus.rs1_busy = '0;
    bus.rs2_busy = '0;
    bus.rs1_tag  = '0;
    bus.rs2_tag  = '0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      lk1[i] = cdb_clear(table_reg[bus.rs1[i]], bus.cdb_valid, bus.cdb_tag);
      lk2[i] = cdb_clear(table_reg[bus.rs2[i]], bus.cdb_valid, bus.cdb_tag);
      for (int j = 0; j < DISPATCH_W; j++) begin
        if (j < i && bus.we[j] && bus.rd[j] == bus.rs1[i]) lk1[i] = '{busy: 1'b1, tag: bus.tag_in[j]};
        if (j < i && bus.we[j] && bus.rd[j] == bus.rs2[i]) lk2[i] = '{busy: 1'b1, tag: bus.tag_in[j]};
      end
      if (bus.rs1[i] != '0 && lk1[i].busy) begin
        bus.rs1_busy[i] = 1'b1;
        bus.rs1_tag[i]  = lk1[i].tag;
      end
      if (bus.rs2[i] != '0 && lk2[i].busy) begin
        bus.rs2_busy[i] = 1'b1;
        bus.rs2_tag[i]  = lk2[i].tag;
      end
    end
  end

  // Snapshot sees only the writes up to and including the branch slot.
  always_comb begin
    for (int r = 0; r < NUM_ARCH; r++) begin
      table_clr[r] = cdb_clear(table_reg[r], bus.cdb_valid, bus.cdb_tag);
    end
    table_wr = table_clr;
    snap     = table_clr;
    for (int i = 0; i < DISPATCH_W; i++) begin
      if (bus.we[i] && bus.rd[i] != '0) begin
        table_wr[bus.rd[i]] = '{busy: 1'b1, tag: bus.tag_in[i]};
        if (i <= int'(bus.ckpt_slot)) snap[bus.rd[i]] = '{busy: 1'b1, tag: bus.tag_in[i]};
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CKPT; k++) begin
      for (int r = 0; r < NUM_ARCH; r++) begin
        ckpt_clr[k][r]  = cdb_clear(ckpt_reg[k][r], bus.cdb_valid, bus.cdb_tag);
        ckpt_next[k][r] = (save_en && alloc_id == ID_W'(k)) ? snap[r] : ckpt_clr[k][r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_ARCH; r++) begin
      case (op)
        RAT_OP_FLUSH:   table_next[r] = '0;
        RAT_OP_RESTORE: table_next[r] = restore_hit ? ckpt_clr[bus.restore_id][r] : table_clr[r];
        default:        table_next[r] = table_wr[r];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_ARCH; r++) begin
        table_reg[r] <= '0;
        for (int k = 0; k < NUM_CKPT; k++) ckpt_reg[k][r] <= '0;
      end
    end else begin
      table_reg <= table_next;
      ckpt_reg  <= ckpt_next;
    end
  end

endmodule

// File: tb/tb_rat_ckpt.sv
// Directed scoreboard bench for rat_ckpt: stimulus pushes expectations, a negedge monitor checks them.
module tb_rat_ckpt;
  import rat_pkg::*;

  logic clk;
  logic rst_n;
  int   cyc_cnt;
  int   total;
  int   bad;

  rat_ckpt_if #(.DISPATCH_W(2), .CDB_W(2), .NUM_CKPT(4), .TAG_W(5)) bus ();

  rat_ckpt #(.DISPATCH_W(2), .CDB_W(2), .NUM_CKPT(4), .TAG_W(5), .NUM_ARCH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    int         kind;   // 0 = register lookup, 1 = checkpoint status
    int         slot;
    int         src;
    logic       busy;
    logic [4:0] tag;
    logic [1:0] id;
    logic       full;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t it;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      logic       ab;
      logic [4:0] at;
      it = exp_q.pop_front();
      total++;
      if (it.kind == 0) begin
        ab = (it.src == 0) ? bus.rs1_busy[it.slot] : bus.rs2_busy[it.slot];
        at = (it.src == 0) ? bus.rs1_tag[it.slot]  : bus.rs2_tag[it.slot];
        if (ab !== it.busy || at !== it.tag) begin
          bad++;
          $display("FAIL %s: got busy=%0d tag=%0d, want busy=%0d tag=%0d", it.name, ab, at, it.busy, it.tag);
        end else begin
          $display("ok   %s: busy=%0d tag=%0d", it.name, ab, at);
        end
      end else begin
        if (bus.ckpt_id !== it.id || bus.ckpt_full !== it.full || bus.ckpt_ovf !== it.ovf) begin
          bad++;
          $display("FAIL %s: got id=%0d full=%0d ovf=%0d, want id=%0d full=%0d ovf=%0d",
                   it.name, bus.ckpt_id, bus.ckpt_full, bus.ckpt_ovf, it.id, it.full, it.ovf);
        end else begin
          $display("ok   %s: id=%0d full=%0d ovf=%0d", it.name, bus.ckpt_id, bus.ckpt_full, bus.ckpt_ovf);
        end
      end
    end
  end

  task automatic idle();
    bus.rs1 = '0; bus.rs2 = '0; bus.we = '0; bus.rd = '0; bus.tag_in = '0;
    bus.cdb_valid = '0; bus.cdb_tag = '0; bus.ckpt_save = 1'b0; bus.ckpt_slot = '0;
    bus.restore = 1'b0; bus.restore_id = '0; bus.ckpt_free_mask = '0; bus.flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  // port: 0 = slot0 rs1, 1 = slot0 rs2, 2 = slot1 rs1, 3 = slot1 rs2
  task automatic q(input int port, input int r, input bit b, input int t, input string nm);
    exp_t e;
    int   s;
    s = port / 2;
    if (port % 2 == 0) bus.rs1[s] = 5'(r);
    else               bus.rs2[s] = 5'(r);
    e = '{name: nm, kind: 0, slot: s, src: port % 2, busy: b, tag: 5'(t),
          id: 2'd0, full: 1'b0, ovf: 1'b0, cyc: cyc_cnt};
    exp_q.push_back(e);
  endtask

  task automatic ck(input int id, input bit full, input bit ovf, input string nm);
    exp_t e;
    e = '{name: nm, kind: 1, slot: 0, src: 0, busy: 1'b0, tag: 5'd0,
          id: 2'(id), full: full, ovf: ovf, cyc: cyc_cnt};
    exp_q.push_back(e);
  endtask

  task automatic wr(input int s, input int r, input int t);
    bus.we[s]     = 1'b1;
    bus.rd[s]     = 5'(r);
    bus.tag_in[s] = 5'(t);
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc_cnt = 0;
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    q(0, 1, 0, 0, "reset_rs1"); q(1, 2, 0, 0, "reset_rs2"); ck(0, 0, 0, "reset_ckpt");
    step();

    // Intra-group forwarding and highest-slot-wins
    wr(0, 3, 5); wr(1, 3, 6);
    q(2, 3, 1, 5, "fwd_slot0_to_slot1"); q(0, 3, 0, 0, "slot0_no_self_fwd");
    step();
    q(0, 3, 1, 6, "same_rd_high_slot");
    step();

    // Write beats CDB on same register; CDB with other tag leaves entry alone
    wr(0, 4, 7);
    step();
    bus.cdb_valid[0] = 1'b1; bus.cdb_tag[0] = 5'd7; wr(0, 4, 9);
    q(0, 4, 0, 0, "cdb_bypass_lookup"); q(2, 4, 1, 9, "fwd_over_cdb");
    step();
    q(0, 4, 1, 9, "write_wins_cdb");
    wr(0, 5, 8);
    step();
    bus.cdb_valid[0] = 1'b1; bus.cdb_tag[0] = 5'd7;
    q(0, 5, 1, 8, "cdb_tag_mismatch_lookup");
    step();
    q(0, 5, 1, 8, "cdb_tag_mismatch_kept");
    step();

    // Checkpoint taken at slot 0, then restored
    wr(0, 1, 2); wr(1, 1, 3); bus.ckpt_save = 1'b1; bus.ckpt_slot = 1'b0;
    ck(0, 0, 0, "save_grant0");
    step();
    q(0, 1, 1, 3, "table_after_save"); ck(1, 0, 0, "next_id1");
    bus.restore = 1'b1; bus.restore_id = 2'd0;
    step();
    q(0, 1, 1, 2, "restored_x1"); q(1, 4, 1, 9, "restored_x4"); ck(0, 0, 0, "restore_frees");
    bus.ckpt_save = 1'b1; bus.ckpt_slot = 1'b1;
    step();
    bus.cdb_valid[1] = 1'b1; bus.cdb_tag[1] = 5'd2;
    q(0, 1, 0, 0, "cdb_port1_bypass"); ck(1, 0, 0, "one_ckpt_live");
    step();
    wr(0, 1, 13);
    step();
    q(0, 1, 1, 13, "x1_renamed_13");
    bus.restore = 1'b1; bus.restore_id = 2'd0;
    step();
    q(0, 1, 0, 0, "ckpt_cdb_cleared"); q(1, 3, 1, 6, "ckpt_kept_x3"); ck(0, 0, 0, "restore2_frees");
    step();

    // Fill all checkpoints, overflow, free one
    for (int n = 0; n < 4; n++) begin
      bus.ckpt_save = 1'b1;
      ck(n, 0, 0, $sformatf("fill_save%0d", n));
      step();
    end
    ck(0, 1, 0, "full_no_save");
    step();
    bus.ckpt_save = 1'b1;
    ck(0, 1, 1, "ovf_pulse");
    step();
    bus.ckpt_free_mask = 4'b0010;
    ck(0, 1, 0, "ovf_cleared");
    step();
    bus.ckpt_save = 1'b1;
    ck(1, 0, 0, "reuse_freed_id1");
    step();
    ck(0, 1, 0, "full_again");
    wr(0, 6, 14);
    step();
    q(0, 6, 1, 14, "x6_before_reset");
    step();

    // Asynchronous reset mid-operation
    rst_n = 1'b0;
    bus.ckpt_save = 1'b1;
    #1;
    q(0, 6, 0, 0, "x6_in_reset"); ck(0, 0, 0, "ckpt_in_reset");
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    q(0, 6, 0, 0, "x6_after_reset");
    step();

    // x0 never renamed; flush overrides restore, writes and saves
    wr(0, 0, 10);
    q(2, 0, 0, 0, "x0_no_fwd");
    step();
    q(0, 0, 0, 0, "x0_not_busy");
    wr(0, 7, 11); bus.ckpt_save = 1'b1;
    step();
    q(0, 7, 1, 11, "x7_before_flush");
    bus.flush = 1'b1; bus.restore = 1'b1; bus.restore_id = 2'd0;
    bus.ckpt_save = 1'b1; wr(1, 8, 15);
    ck(1, 0, 0, "flush_cycle_ckpt");
    step();
    q(0, 7, 0, 0, "flush_x7"); q(1, 8, 0, 0, "flush_drops_write");
    q(2, 1, 0, 0, "flush_x1"); ck(0, 0, 0, "flush_ckpt_empty");
    step();

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
